// File: rtl/hazard_fwd_if.sv
// Decode-stage hazard/forwarding bus between the pipeline (master) and the
// hazard/forwarding unit (slave). AW/CW must match the unit's parameters.
interface hazard_fwd_if #(
    parameter int AW = 5,
    parameter int CW = 16
);
    logic [AW-1:0] RA;
    logic [AW-1:0] RB;
    logic          ra_used;
    logic          rb_used;
    logic [AW-1:0] RW_id;
    logic          wr_en_id;
    logic          is_load_id;
    logic          imm_sel_id;
    logic          hold_in;

    logic [1:0]    mux_sel_A;
    logic [1:0]    mux_sel_B;
    logic          imm_sel;
    logic          stall;
    logic [CW-1:0] stall_cnt;

    modport master (
        output RA, RB, ra_used, rb_used, RW_id, wr_en_id, is_load_id,
               imm_sel_id, hold_in,
        input  mux_sel_A, mux_sel_B, imm_sel, stall, stall_cnt
    );

    modport slave (
        input  RA, RB, ra_used, rb_used, RW_id, wr_en_id, is_load_id,
               imm_sel_id, hold_in,
        output mux_sel_A, mux_sel_B, imm_sel, stall, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand-forwarding control for a short in-order
// pipeline. Tracks the three instructions ahead of decode and picks, per
// operand, the youngest in-flight producer; stalls one cycle on load-use.
module hazard_fwd_unit #(
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_fwd_if.slave   bus
);
    typedef enum logic [1:0] {
        SRC_AR = 2'b00,
        SRC_EX = 2'b01,
        SRC_DM = 2'b10,
        SRC_WB = 2'b11
    } src_e;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] dest;
        logic          load;
    } entry_t;

    entry_t        age1_q, age2_q, age3_q;
    entry_t        id_entry;
    src_e          sel_a_q, sel_b_q;
    src_e          sel_a_d, sel_b_d;
    logic          imm_sel_q;
    logic [CW-1:0] stall_cnt_q;
    logic          a_m1, a_m2, a_m3;
    logic          b_m1, b_m2, b_m3;
    logic          stall_c;

    // Decode-stage entry; writes to register 0 are never tracked.
    always_comb begin
        id_entry       = '0;
        id_entry.valid = bus.wr_en_id && (bus.RW_id != '0);
        id_entry.dest  = bus.RW_id;
        id_entry.load  = bus.is_load_id;
    end

    // Per-age operand matches, source priority and load-use stall detect.
    always_comb begin
        a_m1 = bus.ra_used && age1_q.valid && (age1_q.dest == bus.RA);
        a_m2 = bus.ra_used && age2_q.valid && (age2_q.dest == bus.RA);
        a_m3 = bus.ra_used && age3_q.valid && (age3_q.dest == bus.RA);
        b_m1 = bus.rb_used && !bus.imm_sel_id && age1_q.valid && (age1_q.dest == bus.RB);
        b_m2 = bus.rb_used && !bus.imm_sel_id && age2_q.valid && (age2_q.dest == bus.RB);
        b_m3 = bus.rb_used && !bus.imm_sel_id && age3_q.valid && (age3_q.dest == bus.RB);

        sel_a_d = SRC_AR;
        if (a_m1)      sel_a_d = SRC_EX;
        else if (a_m2) sel_a_d = SRC_DM;
        else if (a_m3) sel_a_d = SRC_WB;

        sel_b_d = SRC_AR;
        if (b_m1)      sel_b_d = SRC_EX;
        else if (b_m2) sel_b_d = SRC_DM;
        else if (b_m3) sel_b_d = SRC_WB;

        stall_c = !rst && !bus.hold_in && age1_q.valid && age1_q.load && (a_m1 || b_m1);
    end

    // Age pipeline, registered selects and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            age1_q      <= '0;
            age2_q      <= '0;
            age3_q      <= '0;
            sel_a_q     <= SRC_AR;
            sel_b_q     <= SRC_AR;
            imm_sel_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else if (!bus.hold_in) begin
            age3_q <= age2_q;
            age2_q <= age1_q;
            if (stall_c) begin
                // Bubble in behind the load; the ID instruction is re-evaluated
                // next cycle with the load one age older.
                age1_q    <= '0;
                sel_a_q   <= SRC_AR;
                sel_b_q   <= SRC_AR;
                imm_sel_q <= 1'b0;
                if (stall_cnt_q != '1)
                    stall_cnt_q <= stall_cnt_q + 1'b1;
            end else begin
                age1_q    <= id_entry;
                sel_a_q   <= sel_a_d;
                sel_b_q   <= sel_b_d;
                imm_sel_q <= bus.imm_sel_id;
            end
        end
    end

    assign bus.mux_sel_A = sel_a_q;
    assign bus.mux_sel_B = sel_b_q;
    assign bus.imm_sel   = imm_sel_q;
    assign bus.stall     = stall_c;
    assign bus.stall_cnt = stall_cnt_q;
endmodule
